bullet_slot_scheduler: RTL and testbench
========================================

Name: bullet_slot_scheduler

Overview:
Sits between the player shoot controls and the pool of bullet slot instances. Sequences all firing and retiring:
- edge-qualifies shoot requests;
- enforces a fire cooldown;
- picks a free slot round-robin and emits a one-frame start pulse;
- latches the per-slot direction;
- converts collision hits into per-slot kill pulses.
Runs entirely in the frame clock domain.

Parameters:
NUM_SLOTS, 4, number of bullet slots managed (2..8)
COOLDOWN, 8, frames between consecutive fires (1..255)
PEND_FRAMES, 15, frames a shot waits for a free slot before being dropped (1..255)

Ports:
clk_60hz  in  1  frame clock, one tick per video frame
reset  in  1  synchronous, active-high
shoot_up  in  1  level, fire upward request
shoot_down  in  1  level, fire downward request
in_use  in  NUM_SLOTS  per-slot busy flag from bullet instances
hit  in  NUM_SLOTS  per-slot collision flag from collision logic
fire  out  NUM_SLOTS  one-frame start pulse, at most one bit set
kill  out  NUM_SLOTS  one-frame retire pulse to slot reset
fire_dir  out  NUM_SLOTS  latched direction per slot, 1=up
all_busy  out  1  no slot free or reserved-free this frame
shots_fired  out  8  total fires, wraps 255->0
shots_dropped  out  8  pending shots timed out, saturates at 255
state  out  2  FSM state for debug

Behaviour:
- Interface: one clock, clk_60hz; reset is synchronous and active-high, port named reset. All outputs are registered.
- Reset values:
  - fire=0, kill=0, fire_dir=0, all_busy=0;
  - shots_fired=0, shots_dropped=0;
  - state=IDLE(0), rr_ptr=0, cooldown and pending counters=0, reserved=0, prev_shoot=0.
- Request: shoot = shoot_up | shoot_down. Edge = shoot & ~prev_shoot, with prev_shoot registered each frame. Direction = shoot_up, so up wins when both are pressed; it is sampled at the edge and held with the request.
- free[i] = ~in_use[i] & ~reserved[i]. reserved[i] is set in the frame fire[i] pulses and cleared the next frame. This covers the one-frame lag before in_use rises.
- Slot pick: the first free index searched from rr_ptr upward, wrapping modulo NUM_SLOTS. After a fire on slot k, rr_ptr = (k+1) mod NUM_SLOTS.
- FSM states:
  - IDLE(0):
    - edge with a free slot -> fire pulse next frame, go to COOLDOWN;
    - edge with no free slot -> PENDING, pending counter loaded with PEND_FRAMES.
  - PENDING(1): each frame, if a slot is free -> fire, go to COOLDOWN. Otherwise decrement the counter. At 0: shots_dropped++ (saturating), go to WAIT_REL. A second edge while in PENDING is ignored.
  - COOLDOWN(2): counter is loaded with COOLDOWN on the fire and decremented per frame. At 0: go to WAIT_REL if shoot is still high, else IDLE. Edges during COOLDOWN are discarded, not queued.
  - WAIT_REL(3): go to IDLE when shoot=0.
- Fire frame:
  - exactly one fire[k]=1 for one frame;
  - fire_dir[k] <= latched direction;
  - shots_fired++ (wrapping).
  - fire_dir of other slots is unchanged.
- Latency: edge at frame n with a free slot -> fire asserted at n+1.
- Kill: kill[i] <= hit[i] & in_use[i], one-frame pulse, independent of the FSM. A hit on an idle slot is ignored.
- Kill and a same-slot fire cannot coincide: a killed slot is still in_use that frame, so it is not free.
- all_busy <= ~|free, updated every frame.
- Reset mid-operation: returns to IDLE at once. Any pending shot is discarded without a drop count. fire and kill are forced low in the reset frame.

Optional Feature:
BULLET_AUTOFIRE_EN:
- Defined: in COOLDOWN, when the counter reaches 0 with shoot still high, a new request is raised as if an edge occurred, with the direction re-sampled. Holding the button fires every COOLDOWN+1 frames while slots are free. WAIT_REL is entered only from a PENDING timeout.
- Undefined: behaviour exactly as above; one shot per press.

Test Plan:
- All slots idle, shoot_up pulses at frame 10 -> fire=0001 at frame 11, fire_dir[0]=1, shots_fired=1, state=COOLDOWN.
- Four separate presses, each after cooldown, with in_use following fire one frame later -> fire sequence 0001, 0010, 0100, 1000. A fifth press with all in_use=1 -> PENDING, all_busy=1.
- In PENDING (PEND_FRAMES=15), drop in_use[2] after 5 frames -> fire=0100 the next frame, shots_dropped stays 0. Repeat with no slot freed -> shots_dropped=1 after 15 frames, state=WAIT_REL.
- hit=0010 with in_use=0010 -> kill=0010 for one frame. hit=0100 with in_use[2]=0 -> kill=0000.
- shoot_up and shoot_down rise together -> fire_dir=1. A press during cooldown produces no fire. Assert reset in PENDING -> state=IDLE, counters 0, no fire.
- With BULLET_AUTOFIRE_EN and COOLDOWN=8, hold shoot_down for 30 frames with slots free -> fires at frames 1, 10, 19, 28, rotating through slots, all with fire_dir=0.

Source files
------------

// File: rtl/bullet_slot_scheduler.sv
// Bullet slot scheduler: edge-qualified shooting, cooldown, round-robin slot pick.
// Optional hold-to-autofire behaviour is enabled by defining BULLET_AUTOFIRE_EN.
module bullet_slot_scheduler #(
  parameter int NUM_SLOTS   = 4,
  parameter int COOLDOWN    = 8,
  parameter int PEND_FRAMES = 15
) (
  input  logic                 clk_60hz,
  input  logic                 reset,
  input  logic                 shoot_up,
  input  logic                 shoot_down,
  input  logic [NUM_SLOTS-1:0] in_use,
  input  logic [NUM_SLOTS-1:0] hit,
  output logic [NUM_SLOTS-1:0] fire,
  output logic [NUM_SLOTS-1:0] kill,
  output logic [NUM_SLOTS-1:0] fire_dir,
  output logic                 all_busy,
  output logic [7:0]           shots_fired,
  output logic [7:0]           shots_dropped,
  output logic [1:0]           state
);

  localparam int PW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [7:0] CD_LOAD = 8'(COOLDOWN);
  localparam logic [7:0] PD_LOAD = 8'(PEND_FRAMES);
  localparam logic [PW-1:0] LAST = PW'(NUM_SLOTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_COOL = 2'd2,
    ST_WAIT = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 prev_shoot_q, prev_shoot_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [NUM_SLOTS-1:0] reserved_q, reserved_d;
  logic                 dir_q, dir_d;
  logic [NUM_SLOTS-1:0] fire_q, fire_d;
  logic [NUM_SLOTS-1:0] kill_q, kill_d;
  logic [NUM_SLOTS-1:0] fire_dir_q, fire_dir_d;
  logic                 all_busy_q, all_busy_d;
  logic [7:0]           fired_q, fired_d;
  logic [7:0]           dropped_q, dropped_d;
`ifdef BULLET_AUTOFIRE_EN
  logic                 auto_q, auto_d;
`endif

  logic                 shoot;
  logic                 edge_det;
  logic [NUM_SLOTS-1:0] free;
  logic                 any_free;
  logic                 found;
  int                   idx;
  logic [PW-1:0]        pick_idx;
  logic [NUM_SLOTS-1:0] pick_oh;
  logic [PW-1:0]        rr_next;
  logic                 req;
  logic                 req_dir;
  logic                 do_fire;
  logic                 fire_up;
  logic [7:0]           cnt_dec;

  // Request qualification and slot availability for this frame
  always_comb begin
    shoot    = shoot_up | shoot_down;
    edge_det = shoot & ~prev_shoot_q;
    free     = ~in_use & ~reserved_q;
    any_free = |free;
`ifdef BULLET_AUTOFIRE_EN
    req      = edge_det | auto_q;
    req_dir  = edge_det ? shoot_up : dir_q;
`else
    req      = edge_det;
    req_dir  = shoot_up;
`endif
  end

  // Round-robin search for the first free slot at or after rr_ptr
  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    idx      = 0;
    pick_oh  = '0;
    for (int off = 0; off < NUM_SLOTS; off++) begin
      idx = int'(rr_ptr_q) + off;
      if (idx >= NUM_SLOTS) idx = idx - NUM_SLOTS;
      if (!found && free[idx[PW-1:0]]) begin
        found    = 1'b1;
        pick_idx = idx[PW-1:0];
      end
    end
    if (found) pick_oh[pick_idx] = 1'b1;
    rr_next = (pick_idx == LAST) ? '0 : pick_idx + PW'(1);
  end

  // Next-state, counters and output pulses
  always_comb begin
    state_d      = state_q;
    prev_shoot_d = shoot;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    reserved_d   = '0;
    dir_d        = dir_q;
    fire_d       = '0;
    kill_d       = hit & in_use;
    fire_dir_d   = fire_dir_q;
    all_busy_d   = ~any_free;
    fired_d      = fired_q;
    dropped_d    = dropped_q;
`ifdef BULLET_AUTOFIRE_EN
    auto_d       = 1'b0;
`endif
    do_fire      = 1'b0;
    fire_up      = dir_q;
    cnt_dec      = cnt_q - 8'd1;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          dir_d = req_dir;
          if (any_free) begin
            do_fire = 1'b1;
            fire_up = req_dir;
          end else begin
            state_d = ST_PEND;
            cnt_d   = PD_LOAD;
          end
        end
      end
      ST_PEND: begin
        if (any_free) begin
          do_fire = 1'b1;
        end else begin
          cnt_d = cnt_dec;
          if (cnt_dec == 8'd0) begin
            state_d = ST_WAIT;
            if (dropped_q != 8'hFF) dropped_d = dropped_q + 8'd1;
          end
        end
      end
      ST_COOL: begin
        cnt_d = cnt_dec;
        if (cnt_dec == 8'd0) begin
`ifdef BULLET_AUTOFIRE_EN
          state_d = ST_IDLE;
          if (shoot) begin
            auto_d = 1'b1;
            dir_d  = shoot_up;
          end
`else
          state_d = shoot ? ST_WAIT : ST_IDLE;
`endif
        end
      end
      ST_WAIT: begin
        if (!shoot) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_fire) begin
      fire_d     = pick_oh;
      reserved_d = pick_oh;
      fire_dir_d = (fire_dir_q & ~pick_oh)
                 | ({NUM_SLOTS{fire_up}} & pick_oh);
      rr_ptr_d   = rr_next;
      fired_d    = fired_q + 8'd1;
      state_d    = ST_COOL;
      cnt_d      = CD_LOAD;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk_60hz) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      prev_shoot_q <= 1'b0;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      reserved_q   <= '0;
      dir_q        <= 1'b0;
      fire_q       <= '0;
      kill_q       <= '0;
      fire_dir_q   <= '0;
      all_busy_q   <= 1'b0;
      fired_q      <= '0;
      dropped_q    <= '0;
`ifdef BULLET_AUTOFIRE_EN
      auto_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      prev_shoot_q <= prev_shoot_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      reserved_q   <= reserved_d;
      dir_q        <= dir_d;
      fire_q       <= fire_d;
      kill_q       <= kill_d;
      fire_dir_q   <= fire_dir_d;
      all_busy_q   <= all_busy_d;
      fired_q      <= fired_d;
      dropped_q    <= dropped_d;
`ifdef BULLET_AUTOFIRE_EN
      auto_q       <= auto_d;
`endif
    end
  end

  assign fire          = fire_q;
  assign kill          = kill_q;
  assign fire_dir      = fire_dir_q;
  assign all_busy      = all_busy_q;
  assign shots_fired   = fired_q;
  assign shots_dropped = dropped_q;
  assign state         = state_q;

endmodule

// File: tb/tb_bullet_slot_scheduler.sv
// Bench for bullet_slot_scheduler: directed scenarios then randomized play
// against a frame-timestamp reference model.
module tb_bullet_slot_scheduler;

  localparam int N  = 4;
  localparam int CD = 8;
  localparam int PD = 15;

  logic         clk = 1'b0;
  logic         reset;
  logic         shoot_up, shoot_down;
  logic [N-1:0] in_use, hit;
  logic [N-1:0] fire, kill, fire_dir;
  logic         all_busy;
  logic [7:0]   shots_fired, shots_dropped;
  logic [1:0]   state;

  bullet_slot_scheduler #(
    .NUM_SLOTS(N), .COOLDOWN(CD), .PEND_FRAMES(PD)
  ) dut (
    .clk_60hz(clk), .reset(reset),
    .shoot_up(shoot_up), .shoot_down(shoot_down),
    .in_use(in_use), .hit(hit),
    .fire(fire), .kill(kill), .fire_dir(fire_dir),
    .all_busy(all_busy),
    .shots_fired(shots_fired), .shots_dropped(shots_dropped),
    .state(state)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // reference model: registered values plus absolute frame deadlines
  int           m_t;
  int           m_st;
  logic         m_prev, m_dir, m_auto, m_busy;
  logic [N-1:0] m_fire, m_kill, m_fdir;
  int           m_rr;
  logic [7:0]   m_fired, m_dropped;
  int           m_deadline, m_cool_end;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_st = 0; m_prev = 0; m_dir = 0; m_auto = 0; m_busy = 0;
    m_fire = '0; m_kill = '0; m_fdir = '0; m_rr = 0;
    m_fired = 0; m_dropped = 0; m_deadline = 0; m_cool_end = 0;
  endtask

  task automatic model_step(input logic up, input logic dn,
                            input logic [N-1:0] u, input logic [N-1:0] h);
    logic shoot, edg, anyf, req, rdir, do_f, fdir, auto_n;
    logic [N-1:0] free, nf;
    int nst, k;
    shoot = up | dn;
    edg = shoot & ~m_prev;
    free = ~u & ~m_fire;
    anyf = (free != 0);
    nst = m_st; do_f = 0; fdir = m_dir; auto_n = 0;
    case (m_st)
      0: begin
        req = edg; rdir = up;
`ifdef BULLET_AUTOFIRE_EN
        req = edg | m_auto;
        if (!edg) rdir = m_dir;
`endif
        if (req) begin
          m_dir = rdir;
          if (anyf) begin do_f = 1; fdir = rdir; end
          else begin nst = 1; m_deadline = m_t + PD; end
        end
      end
      1: begin
        if (anyf) do_f = 1;
        else if (m_t == m_deadline) begin
          nst = 3;
          if (m_dropped != 8'hFF) m_dropped = m_dropped + 1;
        end
      end
      2: begin
        if (m_t == m_cool_end) begin
`ifdef BULLET_AUTOFIRE_EN
          nst = 0;
          if (shoot) begin auto_n = 1; m_dir = up; end
`else
          nst = shoot ? 3 : 0;
`endif
        end
      end
      default: if (!shoot) nst = 0;
    endcase
    nf = '0;
    if (do_f) begin
      k = -1;
      for (int off = 0; off < N; off++)
        if (k < 0 && free[(m_rr + off) % N]) k = (m_rr + off) % N;
      nf[k] = 1'b1;
      m_fdir[k] = fdir;
      m_rr = (k + 1) % N;
      m_fired = m_fired + 1;
      nst = 2;
      m_cool_end = m_t + CD;
    end
    m_fire = nf;
    m_kill = h & u;
    m_busy = !anyf;
    m_prev = shoot;
    m_st = nst;
    m_auto = auto_n;
    m_t++;
  endtask

  task automatic check_all();
    chk("fire", fire, m_fire);
    chk("kill", kill, m_kill);
    chk("fire_dir", fire_dir, m_fdir);
    chk("all_busy", all_busy, m_busy);
    chk("shots_fired", shots_fired, m_fired);
    chk("shots_dropped", shots_dropped, m_dropped);
    chk("state", state, m_st);
  endtask

  task automatic frame(input logic up, input logic dn,
                       input logic [N-1:0] u, input logic [N-1:0] h);
    shoot_up = up; shoot_down = dn; in_use = u; hit = h;
    model_step(up, dn, u, h);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1; shoot_up = 0; shoot_down = 0; in_use = '0; hit = '0;
    @(posedge clk);
    #1;
    model_reset();
    reset = 0;
    check_all();
  endtask

  logic [N-1:0] use_v;
  int           life[N];
  logic [N-1:0] armed;
  logic         r_up, r_dn;
  logic [N-1:0] r_hit;
  int           nfires;

  initial begin
    m_t = 0;
    model_reset();
    reset = 1; shoot_up = 0; shoot_down = 0; in_use = '0; hit = '0;

    // reset values
    do_reset();
    chk("rst_state", state, 0);
    chk("rst_fire", fire, 0);
    chk("rst_fired", shots_fired, 0);
    chk("rst_busy", all_busy, 0);

    // single shot upward
    use_v = '0;
    repeat (9) frame(0, 0, use_v, 0);
    frame(1, 0, use_v, 0);
    chk("t1_fire", fire, 4'b0001);
    chk("t1_dir0", fire_dir[0], 1);
    chk("t1_fired", shots_fired, 1);
    chk("t1_state", state, 2);
    frame(0, 0, use_v, 0);
    use_v[0] = 1'b1;
    repeat (10) frame(0, 0, use_v, 0);

    // round-robin over remaining slots
    for (int s = 1; s < N; s++) begin
      frame(0, 1, use_v, 0);
      chk("rr_fire", fire, 1 << s);
      frame(0, 0, use_v, 0);
      use_v[s] = 1'b1;
      repeat (10) frame(0, 0, use_v, 0);
    end

    // all busy -> pending, then slot 2 frees
    frame(0, 1, 4'hF, 0);
    chk("pend_state", state, 1);
    chk("pend_busy", all_busy, 1);
    repeat (4) frame(0, 0, 4'hF, 0);
    frame(0, 0, 4'b1011, 0);
    chk("pend_fire", fire, 4'b0100);
    chk("pend_nodrop", shots_dropped, 0);
    repeat (11) frame(0, 0, 4'hF, 0);

    // pending timeout
    frame(0, 1, 4'hF, 0);
    repeat (14) frame(0, 0, 4'hF, 0);
    chk("to_still_pend", state, 1);
    chk("to_not_yet", shots_dropped, 0);
    frame(0, 0, 4'hF, 0);
    chk("to_dropped", shots_dropped, 1);
    chk("to_wait", state, 3);
    frame(0, 0, 4'hF, 0);
    chk("to_idle", state, 0);

    // kill qualification
    frame(0, 0, 4'b0010, 4'b0010);
    chk("kill_hit", kill, 4'b0010);
    frame(0, 0, 4'b0010, 4'b0000);
    chk("kill_pulse", kill, 4'b0000);
    frame(0, 0, 4'b0010, 4'b0100);
    chk("kill_idle", kill, 4'b0000);

    // both buttons: up wins; press during cooldown ignored
    frame(1, 1, 4'b0000, 0);
    chk("both_fire", fire, 4'b1000);
    chk("both_dir", fire_dir[3], 1);
    frame(0, 0, 4'b0000, 0);
    frame(0, 1, 4'b1000, 0);
    chk("cool_nofire", fire, 4'b0000);
    chk("cool_state", state, 2);
    repeat (11) frame(0, 0, 4'b1000, 0);

    // reset while pending
    frame(1, 0, 4'hF, 0);
    chk("rp_pend", state, 1);
    repeat (3) frame(0, 0, 4'hF, 0);
    do_reset();
    chk("rp_state", state, 0);
    chk("rp_fire", fire, 0);
    chk("rp_fired", shots_fired, 0);
    chk("rp_dropped", shots_dropped, 0);

`ifdef BULLET_AUTOFIRE_EN
    // hold shoot_down with free slots: fires every CD+1 frames
    nfires = 0;
    for (int f = 0; f < 30; f++) begin
      frame(0, 1, '0, 0);
      if (fire != 0) nfires++;
    end
    chk("auto_count", nfires, 4);
    chk("auto_dir", fire_dir, 0);
    repeat (12) frame(0, 0, '0, 0);
`endif

    // randomized play with a bullet lifetime model
    for (int k = 0; k < N; k++) life[k] = 0;
    armed = '0; r_up = 0; r_dn = 0;
    for (int f = 0; f < 2000; f++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        for (int k = 0; k < N; k++) life[k] = 0;
        armed = '0;
      end
      for (int k = 0; k < N; k++) use_v[k] = (life[k] > 0);
      for (int k = 0; k < N; k++) r_hit[k] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 4) == 0) r_up = ~r_up;
      if ($urandom_range(0, 4) == 0) r_dn = ~r_dn;
      frame(r_up, r_dn, use_v, r_hit);
      for (int k = 0; k < N; k++) begin
        if (life[k] > 0) life[k]--;
        if (r_hit[k] && use_v[k]) life[k] = 0;
        if (armed[k]) life[k] = $urandom_range(3, 30);
      end
      armed = m_fire;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
